// File: rtl/entropy_control_fsm.sv
// Entropy-driven stall/flush controller: EMA filter on the entropy bus feeding a Moore FSM
// with hysteresis, stall hold, flush pulse and cooldown. Optional macro: ENTROPY_PEAK_BYPASS_EN.
module entropy_control_fsm #(
   parameter int unsigned ENTROPY_W     = 16,
   parameter int unsigned STALL_TH      = 10000,
   parameter int unsigned FLUSH_TH      = 50000,
   parameter int unsigned HYST          = 1000,
   parameter int unsigned AVG_SHIFT     = 2,
   parameter int unsigned STALL_MIN_CYC = 4,
   parameter int unsigned FLUSH_CYC     = 2,
   parameter int unsigned COOLDOWN_CYC  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ctrl_en,
   input  logic                 entropy_valid,
   input  logic [ENTROPY_W-1:0] entropy_in,
   output logic                 entropy_stall,
   output logic                 entropy_flush,
   output logic [ENTROPY_W-1:0] entropy_filt,
   output logic [1:0]           fsm_state,
   output logic [15:0]          flush_cnt
);

   localparam int unsigned DIFF_W  = ENTROPY_W + 1;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned EXIT_TH = (STALL_TH > HYST) ? (STALL_TH - HYST) : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STALL = 2'd1,
      S_FLUSH = 2'd2,
      S_COOL  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [CNT_W-1:0]          r_cnt;
   logic [15:0]               r_flush_cnt;
   logic [ENTROPY_W-1:0]      r_filt;
   logic                      r_stall;
   logic                      r_flush;

   logic signed [DIFF_W-1:0]  w_diff;
   logic signed [DIFF_W-1:0]  w_step;
   logic signed [DIFF_W-1:0]  w_sum;
   logic [ENTROPY_W-1:0]      w_filt_nxt;
   logic                      w_above_flush;
   logic                      w_above_stall;
   logic                      w_below_exit;
   logic                      w_peak;
   logic                      w_stall_done;
   logic                      w_flush_done;
   logic                      w_cool_done;

   // EMA step; the sum always lands in [0, 2^W-1] so the top bit can be dropped
   always_comb begin
      w_diff     = $signed({1'b0, entropy_in}) - $signed({1'b0, r_filt});
      w_step     = w_diff >>> AVG_SHIFT;
      w_sum      = $signed({1'b0, r_filt}) + w_step;
      w_filt_nxt = w_sum[ENTROPY_W-1:0];
   end

   assign w_above_flush = 32'(r_filt) > FLUSH_TH;
   assign w_above_stall = 32'(r_filt) > STALL_TH;
   assign w_below_exit  = 32'(r_filt) < EXIT_TH;
   assign w_stall_done  = (32'(r_cnt) + 32'd1) >= STALL_MIN_CYC;
   assign w_flush_done  = (32'(r_cnt) + 32'd1) >= FLUSH_CYC;
   assign w_cool_done   = (32'(r_cnt) + 32'd1) >= COOLDOWN_CYC;

`ifdef ENTROPY_PEAK_BYPASS_EN
   assign w_peak = entropy_valid && (32'(entropy_in) > FLUSH_TH);
`else
   assign w_peak = 1'b0;
`endif

   // Next-state logic; disable overrides every transition
   always_comb begin
      w_next = r_state;
      if (!ctrl_en) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_peak || w_above_flush)   w_next = S_FLUSH;
               else if (w_above_stall)        w_next = S_STALL;
            end
            S_STALL: begin
               if (w_peak || w_above_flush)   w_next = S_FLUSH;
               else if (w_stall_done && w_below_exit) w_next = S_IDLE;
            end
            S_FLUSH: begin
               if (w_flush_done) w_next = (COOLDOWN_CYC == 0) ? S_IDLE : S_COOL;
            end
            S_COOL: begin
               if (w_cool_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // State, counters and outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_flush_cnt <= '0;
         r_filt      <= '0;
         r_stall     <= 1'b0;
         r_flush     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stall <= (w_next == S_STALL) || (w_next == S_FLUSH);
         r_flush <= (w_next == S_FLUSH);
         if (!ctrl_en || (w_next != r_state)) r_cnt <= '0;
         else if (r_cnt != {CNT_W{1'b1}})     r_cnt <= r_cnt + CNT_W'(1);
         if ((w_next == S_FLUSH) && (r_state != S_FLUSH) && (r_flush_cnt != 16'hFFFF))
            r_flush_cnt <= r_flush_cnt + 16'd1;
         if (entropy_valid) r_filt <= w_filt_nxt;
      end
   end

   assign entropy_stall = r_stall;
   assign entropy_flush = r_flush;
   assign entropy_filt  = r_filt;
   assign fsm_state     = r_state;
   assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_entropy_control_fsm.sv
// Self-checking bench for entropy_control_fsm: directed steps plus random traffic
// compared each cycle against a behavioural model of the controller.
module tb_entropy_control_fsm;

   localparam int STALL_TH  = 10000;
   localparam int FLUSH_TH  = 50000;
   localparam int HYST      = 1000;
   localparam int AVG_SHIFT = 2;
   localparam int STALL_MIN = 4;
   localparam int FLUSH_LEN = 2;
   localparam int COOL_LEN  = 8;
   localparam int P_IDLE = 0, P_STALL = 1, P_FLUSH = 2, P_COOL = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ctrl_en;
   logic        entropy_valid;
   logic [15:0] entropy_in;
   logic        entropy_stall;
   logic        entropy_flush;
   logic [15:0] entropy_filt;
   logic [1:0]  fsm_state;
   logic [15:0] flush_cnt;

   int checks   = 0;
   int failures = 0;

   int m_filt, m_phase, m_age, m_flushes;

   entropy_control_fsm dut (
      .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en),
      .entropy_valid(entropy_valid), .entropy_in(entropy_in),
      .entropy_stall(entropy_stall), .entropy_flush(entropy_flush),
      .entropy_filt(entropy_filt), .fsm_state(fsm_state), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int floor_div_pow2(input int d, input int sh);
      int p, q;
      p = 1 << sh;
      q = d / p;
      if (d < 0 && q * p != d) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_filt = 0; m_phase = P_IDLE; m_age = 0; m_flushes = 0;
   endtask

   // One clock edge of the controller, judged on the filter value before the edge
   task automatic model_step(input bit en, input bit v, input int x);
      int nxt;
      bit peak;
      int exit_th;
      exit_th = (STALL_TH > HYST) ? STALL_TH - HYST : 0;
      peak = 1'b0;
`ifdef ENTROPY_PEAK_BYPASS_EN
      peak = v && (x > FLUSH_TH);
`endif
      nxt = m_phase;
      if (!en) nxt = P_IDLE;
      else if (m_phase == P_IDLE || m_phase == P_STALL) begin
         if (peak || m_filt > FLUSH_TH) nxt = P_FLUSH;
         else if (m_phase == P_IDLE && m_filt > STALL_TH) nxt = P_STALL;
         else if (m_phase == P_STALL && m_age >= STALL_MIN - 1 && m_filt < exit_th) nxt = P_IDLE;
      end else if (m_phase == P_FLUSH) begin
         if (m_age >= FLUSH_LEN - 1) nxt = (COOL_LEN == 0) ? P_IDLE : P_COOL;
      end else if (m_age >= COOL_LEN - 1) nxt = P_IDLE;
      if (nxt == P_FLUSH && m_phase != P_FLUSH && m_flushes < 65535) m_flushes++;
      if (!en || nxt != m_phase) m_age = 0;
      else if (m_age < 65535) m_age++;
      m_phase = nxt;
      if (v) m_filt = m_filt + floor_div_pow2(x - m_filt, AVG_SHIFT);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".stall"}, 32'(entropy_stall), 32'(m_phase == P_STALL || m_phase == P_FLUSH));
      chk({tag, ".flush"}, 32'(entropy_flush), 32'(m_phase == P_FLUSH));
      chk({tag, ".filt"},  32'(entropy_filt),  32'(m_filt));
      chk({tag, ".state"}, 32'(fsm_state),     32'(m_phase));
      chk({tag, ".fcnt"},  32'(flush_cnt),     32'(m_flushes));
   endtask

   // Drive inputs, take one edge, then compare 1 time unit later
   task automatic step(input bit en, input bit v, input int x, input string tag);
      ctrl_en = en; entropy_valid = v; entropy_in = 16'(x);
      @(posedge clk);
      model_step(en, v, x);
      #1;
      check_all(tag);
   endtask

   initial begin
      int flush_hi, cool_hi, lvl, seg, s;
      bit hit;
      int levels[7] = '{2000, 8500, 9600, 12000, 30000, 55000, 65535};

      // Reset held with hostile inputs
      rst_n = 1'b0; ctrl_en = 1'b1; entropy_valid = 1'b1; entropy_in = 16'hFFFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      entropy_valid = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1;
      check_all("release");
      @(posedge clk); model_step(1'b1, 1'b0, 0); #1;

      // Filter ramp on constant 20000
      step(1, 1, 20000, "ramp1"); chk("ramp1.filt", 32'(entropy_filt), 32'd5000);
      step(1, 1, 20000, "ramp2"); chk("ramp2.filt", 32'(entropy_filt), 32'd8750);
      step(1, 1, 20000, "ramp3"); chk("ramp3.filt", 32'(entropy_filt), 32'd11562);
      chk("ramp3.stall", 32'(entropy_stall), 32'd0);
      step(1, 0, 0, "ramp4");
      chk("ramp4.stall", 32'(entropy_stall), 32'd1);
      chk("ramp4.flush", 32'(entropy_flush), 32'd0);

      // Hysteresis: 9500 keeps STALL, 8000 releases it
      step(1, 1, 3314, "hyst_a"); chk("hyst_a.filt", 32'(entropy_filt), 32'd9500);
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0, "hyst_hold");
         chk("hyst_hold.state", 32'(fsm_state), 32'd1);
      end
      step(1, 1, 3500, "hyst_b"); chk("hyst_b.filt", 32'(entropy_filt), 32'd8000);
      chk("hyst_b.state", 32'(fsm_state), 32'd1);
      step(1, 0, 0, "hyst_exit");
      chk("hyst_exit.state", 32'(fsm_state), 32'd0);
      chk("hyst_exit.stall", 32'(entropy_stall), 32'd0);

      // Climb to flush, then abort it in the second flush cycle
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         step(1, 1, 65535, "climb");
         hit = entropy_flush;
      end
      chk("climb.reached", 32'(hit), 32'd1);
      chk("climb.fcnt", 32'(flush_cnt), 32'd1);
      step(1, 1, 65535, "flush2");
      chk("flush2.flush", 32'(entropy_flush), 32'd1);
      step(0, 1, 65535, "abort");
      chk("abort.state", 32'(fsm_state), 32'd0);
      chk("abort.flush", 32'(entropy_flush), 32'd0);
      chk("abort.fcnt", 32'(flush_cnt), 32'd1);
      step(0, 1, 65535, "disabled");
      chk("disabled.state", 32'(fsm_state), 32'd0);

      // Full flush / cooldown / re-flush cycle under persistent high entropy
      flush_hi = 0; cool_hi = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 65535, "cycle");
         if (entropy_flush) flush_hi++;
         if (fsm_state == 2'd3) begin
            cool_hi++;
            chk("cycle.cool_quiet", 32'(entropy_stall | entropy_flush), 32'd0);
         end
      end
      chk("cycle.flush_cycles", 32'(flush_hi), 32'd3);
      chk("cycle.cool_cycles", 32'(cool_hi), 32'd8);
      chk("cycle.state", 32'(fsm_state), 32'd2);
      chk("cycle.fcnt", 32'(flush_cnt), 32'd3);

      // Random traffic around the thresholds
      seg = 0; lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         if (seg == 0) begin
            seg = int'($urandom_range(5, 40));
            lvl = levels[$urandom_range(0, 6)];
         end
         seg--;
         s = lvl + int'($urandom_range(0, 6000)) - 3000;
         if (s < 0) s = 0;
         if (s > 65535) s = 65535;
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), s, "rand");
      end

      // Asynchronous reset in the middle of a stall
      step(1, 1, 0, "drain");
      for (int i = 0; i < 20; i++) step(1, 1, 0, "drain");
      for (int i = 0; i < 20 && fsm_state != 2'd1; i++) step(1, 1, 20000, "to_stall");
      chk("pre_rst.state", 32'(fsm_state), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      entropy_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); model_step(ctrl_en, 1'b0, 0); #1;
      check_all("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
